// File: rtl/mc_control.sv
// Multi-cycle core control unit: FETCH/DECODE/EXECUTE sequencing, datapath strobes and a
// memory wait watchdog that traps into FAULT when a handshake never completes.
module mc_control #(
   parameter int unsigned OPW      = 3,
   parameter int unsigned WAIT_MAX = 15
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [OPW-1:0] opcode,
   input  logic           mem_ready,
   input  logic           ac_zero,
   output logic           rd_mem,
   output logic           wr_mem,
   output logic           ir_on_adr,
   output logic           pc_on_adr,
   output logic           dbus_on_data,
   output logic           data_on_dbus,
   output logic           ld_ir,
   output logic           ld_ac,
   output logic           ld_pc,
   output logic           inc_pc,
   output logic           clr_pc,
   output logic           pass,
   output logic           add,
   output logic           sub,
   output logic           alu_on_dbus,
   output logic           halted,
   output logic           bus_err,
   output logic [2:0]     state
);

   typedef enum logic [2:0] {
      StReset   = 3'd0,
      StFetch   = 3'd1,
      StDecode  = 3'd2,
      StExecute = 3'd3,
      StHalt    = 3'd4,
      StFault   = 3'd5,
      StBad6    = 3'd6,
      StBad7    = 3'd7
   } state_e;

   localparam logic [7:0] WaitLast = 8'(WAIT_MAX - 1);

   state_e     state_q, state_d;
   logic [7:0] wait_q, wait_d;
   logic [7:0] op;

   assign op    = 8'(opcode);
   assign state = state_q;

   always_comb begin
      rd_mem       = 1'b0;
      wr_mem       = 1'b0;
      ir_on_adr    = 1'b0;
      pc_on_adr    = 1'b0;
      dbus_on_data = 1'b0;
      data_on_dbus = 1'b0;
      ld_ir        = 1'b0;
      ld_ac        = 1'b0;
      ld_pc        = 1'b0;
      inc_pc       = 1'b0;
      clr_pc       = 1'b0;
      pass         = 1'b0;
      add          = 1'b0;
      sub          = 1'b0;
      alu_on_dbus  = 1'b0;
      halted       = 1'b0;
      bus_err      = 1'b0;
      state_d      = state_q;

      case (state_q)
         StReset: begin
            clr_pc  = 1'b1;
            state_d = reset ? StReset : StFetch;
         end
         StFetch: begin
            pc_on_adr    = 1'b1;
            rd_mem       = 1'b1;
            data_on_dbus = 1'b1;
            if (mem_ready) begin
               ld_ir   = 1'b1;
               inc_pc  = 1'b1;
               state_d = StDecode;
            end
         end
         StDecode: state_d = StExecute;
         StExecute: begin
            state_d = StFetch;
            case (op)
               8'd0: begin
                  ir_on_adr    = 1'b1;
                  rd_mem       = 1'b1;
                  data_on_dbus = 1'b1;
                  ld_ac        = mem_ready;
                  if (!mem_ready) state_d = StExecute;
               end
               8'd1: begin
                  pass         = 1'b1;
                  ir_on_adr    = 1'b1;
                  dbus_on_data = 1'b1;
                  wr_mem       = 1'b1;
                  if (!mem_ready) state_d = StExecute;
               end
               8'd2: ld_pc = 1'b1;
               8'd3: begin
                  add         = 1'b1;
                  alu_on_dbus = 1'b1;
                  ld_ac       = 1'b1;
               end
               8'd4: begin
                  sub         = 1'b1;
                  alu_on_dbus = 1'b1;
                  ld_ac       = 1'b1;
               end
               8'd5: ld_pc = ac_zero;
               8'd7: state_d = StHalt;
               default: ;
            endcase
         end
         StHalt:  halted  = 1'b1;
         StFault: bus_err = 1'b1;
         default: state_d = StReset;
      endcase

      // Count stalled access cycles; any completed or non-memory cycle restarts the count.
      if ((rd_mem || wr_mem) && !mem_ready) begin
         wait_d = 8'(wait_q + 8'd1);
         if (wait_q == WaitLast) state_d = StFault;
      end else begin
         wait_d = 8'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StReset;
         wait_q  <= 8'd0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control (WAIT_MAX=4): instruction flows, wait stalls, watchdog fault,
// halt and reset recovery, all against hand-computed control vectors.
module tb_mc_control;

   localparam int RD = 14, WR = 13, IRA = 12, PCA = 11, DBD = 10, DOD = 9, LDIR = 8;
   localparam int LDAC = 7, LDPC = 6, INCPC = 5, CLRPC = 4, PASS = 3, ADD = 2, SUB = 1, ALU = 0;

   localparam logic [14:0] C_NONE = 15'd0;
   localparam logic [14:0] C_RST  = 15'd1 << CLRPC;
   localparam logic [14:0] C_FWT  = (15'd1 << RD) | (15'd1 << PCA) | (15'd1 << DOD);
   localparam logic [14:0] C_FRDY = C_FWT | (15'd1 << LDIR) | (15'd1 << INCPC);
   localparam logic [14:0] C_LWT  = (15'd1 << RD) | (15'd1 << IRA) | (15'd1 << DOD);
   localparam logic [14:0] C_LRDY = C_LWT | (15'd1 << LDAC);
   localparam logic [14:0] C_STA  = (15'd1 << PASS) | (15'd1 << IRA) | (15'd1 << DBD)
                                    | (15'd1 << WR);
   localparam logic [14:0] C_LDPC = 15'd1 << LDPC;
   localparam logic [14:0] C_ADD  = (15'd1 << ADD) | (15'd1 << ALU) | (15'd1 << LDAC);
   localparam logic [14:0] C_SUB  = (15'd1 << SUB) | (15'd1 << ALU) | (15'd1 << LDAC);

   logic       clk = 1'b0;
   logic       reset, mem_ready, ac_zero;
   logic [2:0] opcode;
   logic rd_mem, wr_mem, ir_on_adr, pc_on_adr, dbus_on_data, data_on_dbus, ld_ir, ld_ac;
   logic ld_pc, inc_pc, clr_pc, pass, add, sub, alu_on_dbus, halted, bus_err;
   logic [2:0]  state;
   logic [14:0] ctl;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   assign ctl = {rd_mem, wr_mem, ir_on_adr, pc_on_adr, dbus_on_data, data_on_dbus, ld_ir,
                 ld_ac, ld_pc, inc_pc, clr_pc, pass, add, sub, alu_on_dbus};

   mc_control #(.OPW(3), .WAIT_MAX(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .opcode       (opcode),
      .mem_ready    (mem_ready),
      .ac_zero      (ac_zero),
      .rd_mem       (rd_mem),
      .wr_mem       (wr_mem),
      .ir_on_adr    (ir_on_adr),
      .pc_on_adr    (pc_on_adr),
      .dbus_on_data (dbus_on_data),
      .data_on_dbus (data_on_dbus),
      .ld_ir        (ld_ir),
      .ld_ac        (ld_ac),
      .ld_pc        (ld_pc),
      .inc_pc       (inc_pc),
      .clr_pc       (clr_pc),
      .pass         (pass),
      .add          (add),
      .sub          (sub),
      .alu_on_dbus  (alu_on_dbus),
      .halted       (halted),
      .bus_err      (bus_err),
      .state        (state)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_st(input string tag, input logic [2:0] st, input logic [14:0] c);
      #1;
      check({tag, "/state"}, 32'(state), 32'(st));
      check({tag, "/ctl"}, 32'(ctl), 32'(c));
   endtask

   // Runs one single-cycle instruction starting from FETCH with mem_ready=1.
   task automatic exec_single(input string tag, input logic [2:0] op, input logic [14:0] c);
      opcode = op;
      expect_st({tag, "/fetch"}, 3'd1, C_FRDY);
      tick();
      expect_st({tag, "/decode"}, 3'd2, C_NONE);
      tick();
      expect_st({tag, "/exec"}, 3'd3, c);
      tick();
      expect_st({tag, "/back"}, 3'd1, C_FRDY);
   endtask

   initial begin
      reset = 1'b1; mem_ready = 1'b1; opcode = 3'd3; ac_zero = 1'b0;

      tick();
      expect_st("rst1", 3'd0, C_RST);
      check("rst1/halted", 32'(halted), 32'd0);
      check("rst1/bus_err", 32'(bus_err), 32'd0);
      tick();
      expect_st("rst2", 3'd0, C_RST);
      reset = 1'b0;
      expect_st("rst_tail", 3'd0, C_RST);
      tick();
      expect_st("add/fetch", 3'd1, C_FRDY);
      tick();
      expect_st("add/decode", 3'd2, C_NONE);
      tick();
      expect_st("add/exec", 3'd3, C_ADD);
      tick();
      expect_st("add/back", 3'd1, C_FRDY);

      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         expect_st("fwait", 3'd1, C_FWT);
         tick();
      end
      mem_ready = 1'b1;
      expect_st("fwait/done", 3'd1, C_FRDY);
      tick();
      expect_st("fwait/decode", 3'd2, C_NONE);
      tick();
      expect_st("add2/exec", 3'd3, C_ADD);
      tick();

      ac_zero = 1'b1;
      exec_single("jz1", 3'd5, C_LDPC);
      ac_zero = 1'b0;
      exec_single("jz0", 3'd5, C_NONE);
      exec_single("sub", 3'd4, C_SUB);
      exec_single("jmp", 3'd2, C_LDPC);
      exec_single("nop", 3'd6, C_NONE);

      opcode = 3'd0;
      tick();
      mem_ready = 1'b0;
      expect_st("lda/decode", 3'd2, C_NONE);
      tick();
      expect_st("lda/wait1", 3'd3, C_LWT);
      tick();
      expect_st("lda/wait2", 3'd3, C_LWT);
      mem_ready = 1'b1;
      expect_st("lda/done", 3'd3, C_LRDY);
      tick();
      expect_st("lda/back", 3'd1, C_FRDY);

      // Ready arriving in the last allowed wait cycle completes the access.
      tick();
      mem_ready = 1'b0;
      tick();
      for (int i = 0; i < 3; i++) begin
         expect_st("edge/wait", 3'd3, C_LWT);
         tick();
      end
      mem_ready = 1'b1;
      expect_st("edge/ready", 3'd3, C_LRDY);
      tick();
      expect_st("edge/back", 3'd1, C_FRDY);

      opcode = 3'd1;
      tick();
      mem_ready = 1'b0;
      tick();
      expect_st("sta/wait1", 3'd3, C_STA);
      tick();
      expect_st("sta/wait2", 3'd3, C_STA);
      reset = 1'b1;
      tick();
      expect_st("sta/rst", 3'd0, C_RST);
      check("sta/rst/wr_mem", 32'(wr_mem), 32'd0);
      reset = 1'b0;
      mem_ready = 1'b1;
      tick();
      expect_st("sta/refetch", 3'd1, C_FRDY);

      opcode = 3'd0;
      tick();
      mem_ready = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) begin
         expect_st("tmo/wait", 3'd3, C_LWT);
         tick();
      end
      expect_st("tmo/fault", 3'd5, C_NONE);
      check("tmo/bus_err", 32'(bus_err), 32'd1);
      check("tmo/halted", 32'(halted), 32'd0);
      mem_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         expect_st("tmo/stay", 3'd5, C_NONE);
      end
      reset = 1'b1;
      tick();
      expect_st("tmo/rst", 3'd0, C_RST);
      check("tmo/rst/bus_err", 32'(bus_err), 32'd0);
      reset = 1'b0;
      mem_ready = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) begin
         expect_st("ftmo/wait", 3'd1, C_FWT);
         tick();
      end
      expect_st("ftmo/fault", 3'd5, C_NONE);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      mem_ready = 1'b1;
      tick();
      expect_st("hlt/fetch", 3'd1, C_FRDY);

      opcode = 3'd7;
      tick();
      tick();
      expect_st("hlt/exec", 3'd3, C_NONE);
      tick();
      for (int i = 0; i < 10; i++) begin
         expect_st("hlt/stay", 3'd4, C_NONE);
         check("hlt/halted", 32'(halted), 32'd1);
         tick();
      end
      reset = 1'b1;
      tick();
      expect_st("hlt/rst", 3'd0, C_RST);
      check("hlt/rst/halted", 32'(halted), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
